uart_tx_fifo: RTL and testbench

- Buffered UART transmitter: bytes are written into an internal FIFO and serialised on txd as 8N1 frames, LSB first, back-to-back.
- Sits opposite the receive path in host-facing designs: the core pushes result/debug bytes without polling a busy flag per byte.
- Self-contained. Contains its own FIFO and serialiser and does not instantiate any other UART block.

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a serialiser
// that sends frames LSB first, back-to-back, with no idle gap between frames.
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned DEPTH_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            wdata,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_busy,
  output logic                  txd
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [CW-1:0]       LAST_CYCLE = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  bit_end;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign tx_busy = (state != IDLE);
  assign bit_end = (bit_cnt == LAST_CYCLE);
  // full is judged before any same-edge pop, so a write while full is always dropped
  assign push    = wr_en && !full;
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            state <= START;
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              state <= START;
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, checked against
// a frame-position reference model and an independent line decoder.
module tb_uart_tx_fifo;

  localparam int H     = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int BIT   = 2 * H;
  localparam int FRAME = 10 * BIT;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         wr_en = 1'b0;
  logic [7:0]   wdata = 8'h00;
  logic         full, empty, overflow, tx_busy, txd;
  logic [DL2:0] count;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLK_PER_HALF_BIT(H), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wr_en(wr_en), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .tx_busy(tx_busy), .txd(txd)
  );

  always #5 clk = ~clk;

  // Reference model: queue of held bytes and position within the frame on the line.
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_pop, m_full_pre;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_sent.delete();
      m_pos = -1;
      m_ovf = 1'b0;
    end else begin
      m_pop      = (mq.size() != 0) && (m_pos < 0 || m_pos == FRAME - 1);
      m_full_pre = (mq.size() == DEPTH);
      if (wr_en && m_full_pre) m_ovf = 1'b1;
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_sent.push_back(m_byte);
        m_pos = 0;
      end else if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end
      if (wr_en && !m_full_pre) mq.push_back(wdata);
    end
  end

  function automatic logic [7:0] obs();
    return {txd, tx_busy, full, empty, count, overflow};
  endfunction

  function automatic logic [7:0] expv();
    logic [9:0] fr;
    logic [3:0] bi;
    logic       t;
    fr = {1'b1, m_byte, 1'b0};
    bi = 4'(m_pos / BIT);
    t  = (m_pos < 0) ? 1'b1 : fr[bi];
    return {t, m_pos >= 0, mq.size() == DEPTH, mq.size() == 0, 3'(mq.size()), m_ovf};
  endfunction

  // Independent line decoder: samples mid-bit after a falling start edge.
  logic [7:0] dec[$];
  logic       d_act = 1'b0;
  int         d_c = 0;
  logic [7:0] d_sh = 8'h00;
  logic [3:0] d_idx;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (txd == 1'b0) begin
        d_act = 1'b1;
        d_c   = 0;
      end
    end else begin
      d_c++;
      d_idx = 4'(d_c / BIT);
      if (d_c % BIT == H && d_idx >= 1 && d_idx <= 8) d_sh = {txd, d_sh[7:1]};
      if (d_c == 9 * BIT + H) begin
        if (txd == 1'b1) dec.push_back(d_sh);
        d_act = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 8'h90) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs(), 8'h90);
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_idle: got %h expected %h", obs(), expv());
      end
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    dec.delete();
    @(negedge clk);
    wr_en = 1'b1;
    wdata = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (txd !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_after_write: got txd=%b count=%0d expected txd=1 count=1", txd, count);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL single_start_fall: got txd=%b expected 0", txd);
    end
    for (int i = 0; i < 120; i++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL single_wave: got %h expected %h", obs(), expv());
      end
      if (tx_busy) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt !== 80) begin
      errors++;
      $display("FAIL single_busy_len: got %0d expected 80", busy_cnt);
    end
    checks++;
    if (txd !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_end_idle: got txd=%b empty=%b expected 1 1", txd, empty);
    end
    checks++;
    if (dec.size() != 1 || dec[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_decode: got n=%0d byte=%h expected n=1 byte=55", dec.size(),
               dec.size() > 0 ? dec[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs[3] = '{8'hA5, 8'h00, 8'hFF};
    logic [2:0] peak = '0;
    int busy_cnt = 0;
    dec.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL b2b_wave: got %h expected %h", obs(), expv());
      end
      if (count > peak) peak = count;
      if (tx_busy) busy_cnt++;
      wr_en = (i < 3);
      wdata = bs[i < 3 ? i : 0];
    end
    wr_en = 1'b0;
    checks++;
    if (busy_cnt !== 240) begin
      errors++;
      $display("FAIL b2b_busy_len: got %0d expected 240", busy_cnt);
    end
    checks++;
    if (peak !== 3'd2) begin
      errors++;
      $display("FAIL b2b_count_peak: got %0d expected 2", peak);
    end
    checks++;
    if (dec.size() != 3 || dec[0] !== 8'hA5 || dec[1] !== 8'h00 || dec[2] !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_decode: got n=%0d expected A5 00 FF", dec.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b1, b2;
    logic found = 1'b0;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    dec.delete();
    @(negedge clk);
    wr_en = 1'b1;
    wdata = b1;
    @(negedge clk);
    wdata = b2;
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_pos == FRAME - 1 && mq.size() == 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL simul_wave: got %h expected %h", obs(), expv());
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_reach_stop: got timeout expected last stop cycle");
    end
    wr_en = 1'b1;
    wdata = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL simul_count: got %0d expected 1", count);
    end
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL simul_wave2: got %h expected %h", obs(), expv());
      end
    end
    checks++;
    if (dec.size() != 3 || dec[0] !== b1 || dec[1] !== b2 || dec[2] !== 8'h3C) begin
      errors++;
      $display("FAIL simul_decode: got n=%0d expected %h %h 3c", dec.size(), b1, b2);
    end
  endtask

  task automatic test_extremes();
    int   runs[$];
    int   len = 0;
    logic prev = 1'b1;
    logic first = 1'b1;
    logic started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL extremes_wave: got %h expected %h", obs(), expv());
      end
      if (tx_busy) begin
        if (!started) begin
          started = 1'b1;
          first   = txd;
          prev    = txd;
          len     = 1;
        end else if (txd == prev) begin
          len++;
        end else begin
          runs.push_back(len);
          prev = txd;
          len  = 1;
        end
      end
      wr_en = (i < 2);
      wdata = (i == 0) ? 8'h00 : 8'hFF;
    end
    wr_en = 1'b0;
    if (started) runs.push_back(len);
    checks++;
    if (first !== 1'b0 || runs.size() != 4 || runs[0] != 72 || runs[1] != 8 ||
        runs[2] != 8 || runs[3] != 72) begin
      errors++;
      $display("FAIL extremes_runs: got n=%0d first=%b r0=%0d expected 0: 72 8 8 72",
               runs.size(), first, runs.size() > 0 ? runs[0] : -1);
    end
  endtask

  task automatic test_overflow();
    dec.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full: got count=%0d full=%b expected 4 1", count, full);
        end
      end
      wr_en = 1'b1;
      wdata = 8'(i + 1);
    end
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_flag: got ovf=%b count=%0d expected 1 4", overflow, count);
    end
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL ovf_wave: got %h expected %h", obs(), expv());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    checks++;
    if (dec.size() != 5 || dec[0] !== 8'h01 || dec[1] !== 8'h02 || dec[2] !== 8'h03 ||
        dec[3] !== 8'h04 || dec[4] !== 8'h05) begin
      errors++;
      $display("FAIL ovf_decode: got n=%0d expected 01..05", dec.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic found = 1'b0;
    int   high = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wdata = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_pos >= 0 && m_pos / BIT == 4 && m_pos % BIT == 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rst_mid_wave: got %h expected %h", obs(), expv());
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach: got timeout expected data bit 3");
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL rst_mid_queued: got %0d expected 3", count);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h90) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h", obs(), 8'h90);
    end
    @(negedge clk);
    rstn = 1'b1;
    dec.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rst_mid_after: got %h expected %h", obs(), expv());
      end
      if (txd === 1'b1) high++;
    end
    checks++;
    if (high != 200 || dec.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_silent: got high=%0d frames=%0d expected 200 0", high, dec.size());
    end
  endtask

  task automatic test_random();
    logic idle = 1'b0;
    dec.delete();
    m_sent.delete();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rand_wave: got %h expected %h", obs(), expv());
      end
      wr_en = ($urandom_range(0, 9) == 0);
      wdata = 8'($urandom);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rand_drain: got %h expected %h", obs(), expv());
      end
      if (m_pos < 0 && mq.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL rand_drain_timeout: got busy expected idle");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dec.size() != m_sent.size()) begin
      errors++;
      $display("FAIL rand_frames: got %0d expected %0d", dec.size(), m_sent.size());
    end
    for (int k = 0; k < dec.size() && k < m_sent.size(); k++) begin
      checks++;
      if (dec[k] !== m_sent[k]) begin
        errors++;
        $display("FAIL rand_byte%0d: got %h expected %h", k, dec[k], m_sent[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_extremes();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
